lif_neuron_array: RTL and testbench

//   Layer of N_NEURONS leaky integrate-and-fire neurons sharing one binary input

---
 rtl/lif_neuron_array.sv | 191 +++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// ---------------------------------------------------------------------------
// lif_neuron_array
//   A layer of N_NEURONS leaky integrate-and-fire neurons that all see the same
//   binary input vector x. Each neuron owns one row of binary weights, and the
//   rows are loaded LSB-first over a byte-wide configuration stream. A timestep
//   integrates popcount(x & w[n]) into the membrane after an optional
//   arithmetic-shift leak. The result saturates to the membrane range. When it
//   reaches the threshold the neuron spikes, resets its membrane (to zero or by
//   subtracting the threshold) and goes refractory for refrac_len steps.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_valid      strobe for one weight byte on cfg_data
//   cfg_data       8 weight bits; bit k of the stream -> neuron k/N_INPUTS,
//                  input k%N_INPUTS
//   cfg_done       registered; high once every weight bit has been written
//   threshold      signed firing threshold (must be > 0)
//   leak_shift     leak = u >>> leak_shift, 0 disables leak
//   refrac_len     refractory steps loaded after a spike
//   step_valid     apply one timestep using x
//   x              binary input spikes
//   out_valid      one-cycle pulse after each applied step
//   spikes         per-neuron spike flags, held until the next step
//   u_sel          membrane of neuron sel_idx (mux of registers)
//   sel_idx        readout select
// ---------------------------------------------------------------------------
module lif_neuron_array #(
   parameter int N_INPUTS  = 64,
   parameter int N_NEURONS = 4,
   parameter int U_WIDTH   = 8,
   parameter int REFRAC_W  = 3,
   parameter int RESET_SUB = 0,
   localparam int SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_valid,
   input  logic [7:0]           cfg_data,
   output logic                 cfg_done,
   input  logic [U_WIDTH-1:0]   threshold,
   input  logic [2:0]           leak_shift,
   input  logic [REFRAC_W-1:0]  refrac_len,
   input  logic                 step_valid,
   input  logic [N_INPUTS-1:0]  x,
   output logic                 out_valid,
   output logic [N_NEURONS-1:0] spikes,
   output logic [U_WIDTH-1:0]   u_sel,
   input  logic [SEL_W-1:0]     sel_idx
);

   localparam int N_BITS  = N_INPUTS * N_NEURONS;
   localparam int N_BYTES = N_BITS / 8;
   localparam int BYTE_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int SUM_W   = $clog2(N_INPUTS + 1);
   // Eight guard bits leave room for u - leak + sum before saturation.
   localparam int VW      = U_WIDTH + 8;

   logic [N_BITS-1:0]            w_r;
   logic [BYTE_W-1:0]            byte_cnt_r;
   logic                         cfg_done_r;
   logic signed [U_WIDTH-1:0]    u_r       [N_NEURONS];
   logic [REFRAC_W-1:0]          ref_r     [N_NEURONS];
   logic [N_NEURONS-1:0]         spikes_r;
   logic                         out_valid_r;

   logic signed [VW-1:0]         v_wide_s  [N_NEURONS];
   logic signed [U_WIDTH-1:0]    v_sat_s   [N_NEURONS];
   logic signed [U_WIDTH-1:0]    u_nxt_s   [N_NEURONS];
   logic [REFRAC_W-1:0]          ref_nxt_s [N_NEURONS];
   logic [N_NEURONS-1:0]         spk_nxt_s;

   function automatic logic [SUM_W-1:0] popcount(input logic [N_INPUTS-1:0] v);
      logic [SUM_W-1:0] c;
      c = {SUM_W{1'b0}};
      for (int i = 0; i < N_INPUTS; i++) begin
         c = c + {{(SUM_W-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

   // u - leak + sum, evaluated in the widened domain so it cannot wrap.
   function automatic logic signed [VW-1:0] integrate(
      input logic signed [U_WIDTH-1:0] u,
      input logic [2:0]                sh,
      input logic [SUM_W-1:0]          sum
   );
      logic signed [VW-1:0] u_ext;
      logic signed [VW-1:0] leak;
      logic signed [VW-1:0] sum_ext;
      u_ext = {{(VW-U_WIDTH){u[U_WIDTH-1]}}, u};
      if (sh != 3'd0) begin
         leak = u_ext >>> sh;
      end else begin
         leak = {VW{1'b0}};
      end
      sum_ext = {{(VW-SUM_W){1'b0}}, sum};
      return u_ext - leak + sum_ext;
   endfunction

   function automatic logic signed [U_WIDTH-1:0] saturate(input logic signed [VW-1:0] v);
      logic signed [VW-1:0] hi;
      logic signed [VW-1:0] lo;
      hi = {{(VW-U_WIDTH+1){1'b0}}, {(U_WIDTH-1){1'b1}}};
      lo = {{(VW-U_WIDTH+1){1'b1}}, {(U_WIDTH-1){1'b0}}};
      if (v > hi) begin
         return hi[U_WIDTH-1:0];
      end else if (v < lo) begin
         return lo[U_WIDTH-1:0];
      end else begin
         return v[U_WIDTH-1:0];
      end
   endfunction

   // Per-neuron next state for a timestep.
   always_comb begin
      spk_nxt_s = {N_NEURONS{1'b0}};
      for (int n = 0; n < N_NEURONS; n++) begin
         v_wide_s[n]  = {VW{1'b0}};
         v_sat_s[n]   = {U_WIDTH{1'b0}};
         u_nxt_s[n]   = u_r[n];
         ref_nxt_s[n] = ref_r[n];
      end
      for (int n = 0; n < N_NEURONS; n++) begin
         v_wide_s[n] = integrate(u_r[n], leak_shift,
                                 popcount(x & w_r[n*N_INPUTS +: N_INPUTS]));
         v_sat_s[n]  = saturate(v_wide_s[n]);
         if (ref_r[n] != {REFRAC_W{1'b0}}) begin
            // Refractory: count down, membrane frozen, no spike.
            ref_nxt_s[n] = ref_r[n] - {{(REFRAC_W-1){1'b0}}, 1'b1};
         end else if (v_sat_s[n] >= $signed(threshold)) begin
            spk_nxt_s[n] = 1'b1;
            ref_nxt_s[n] = refrac_len;
            if (RESET_SUB != 0) begin
               u_nxt_s[n] = v_sat_s[n] - $signed(threshold);
            end else begin
               u_nxt_s[n] = {U_WIDTH{1'b0}};
            end
         end else begin
            u_nxt_s[n] = v_sat_s[n];
         end
      end
   end

   // Weight loading: one byte per strobe until the array is full, then locked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_r        <= {N_BITS{1'b0}};
         byte_cnt_r <= {BYTE_W{1'b0}};
         cfg_done_r <= 1'b0;
      end else if (cfg_valid && !cfg_done_r) begin
         w_r[{byte_cnt_r, 3'b000} +: 8] <= cfg_data;
         byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
         if (byte_cnt_r == BYTE_W'(N_BYTES - 1)) begin
            cfg_done_r <= 1'b1;
         end else begin
            cfg_done_r <= 1'b0;
         end
      end else begin
         cfg_done_r <= cfg_done_r;
      end
   end

   // Neuron state: updated only on a step, otherwise held (no leak while idle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < N_NEURONS; n++) begin
            u_r[n]   <= {U_WIDTH{1'b0}};
            ref_r[n] <= {REFRAC_W{1'b0}};
         end
         spikes_r    <= {N_NEURONS{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= step_valid;
         if (step_valid) begin
            for (int n = 0; n < N_NEURONS; n++) begin
               u_r[n]   <= u_nxt_s[n];
               ref_r[n] <= ref_nxt_s[n];
            end
            spikes_r <= spk_nxt_s;
         end else begin
            spikes_r <= spikes_r;
         end
      end
   end

   assign cfg_done  = cfg_done_r;
   assign out_valid = out_valid_r;
   assign spikes    = spikes_r;
   assign u_sel     = u_r[sel_idx];

endmodule

// File: tb/tb_lif_neuron_array.sv
// ---------------------------------------------------------------------------
// tb_lif_neuron_array
//   Directed bench. It drives two instances with the same stimulus: one resets
//   the membrane to zero on a spike, the other subtracts the threshold. Every
//   expected value below is worked out by hand from the neuron equations.
// ---------------------------------------------------------------------------
module tb_lif_neuron_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic [7:0]  cfg_data;
   logic [7:0]  threshold;
   logic [2:0]  leak_shift;
   logic [2:0]  refrac_len;
   logic        step_valid;
   logic [63:0] x;
   logic [1:0]  sel_idx;

   logic        cfg_done0, cfg_done1;
   logic        out_valid0, out_valid1;
   logic [3:0]  spikes0, spikes1;
   logic [7:0]  u_sel0, u_sel1;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

   lif_neuron_array #(.RESET_SUB(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_done(cfg_done0), .threshold(threshold), .leak_shift(leak_shift),
      .refrac_len(refrac_len), .step_valid(step_valid), .x(x),
      .out_valid(out_valid0), .spikes(spikes0), .u_sel(u_sel0), .sel_idx(sel_idx)
   );

   lif_neuron_array #(.RESET_SUB(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_done(cfg_done1), .threshold(threshold), .leak_shift(leak_shift),
      .refrac_len(refrac_len), .step_valid(step_valid), .x(x),
      .out_valid(out_valid1), .spikes(spikes1), .u_sel(u_sel1), .sel_idx(sel_idx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Membrane of every neuron in both instances (all neurons see identical data).
   task automatic check_u(input string tag, input int e0, input int e1);
      for (int n = 0; n < 4; n++) begin
         sel_idx = 2'(n);
         #1;
         check_eq({tag, "_u0"}, 32'(u_sel0), 32'(e0));
         check_eq({tag, "_u1"}, 32'(u_sel1), 32'(e1));
      end
   endtask

   task automatic check_out(input string tag, input logic ov, input logic [3:0] spk);
      check_eq({tag, "_ov0"}, 32'(out_valid0), 32'(ov));
      check_eq({tag, "_ov1"}, 32'(out_valid1), 32'(ov));
      check_eq({tag, "_spk0"}, 32'(spikes0), 32'(spk));
      check_eq({tag, "_spk1"}, 32'(spikes1), 32'(spk));
   endtask

   task automatic do_step(input logic [63:0] xv);
      step_valid = 1'b1;
      x          = xv;
      @(posedge clk);
      @(negedge clk);
      step_valid = 1'b0;
      x          = 64'd0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      cfg_valid = 1'b1;
      cfg_data  = b;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_data  = 8'd0;
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_data   = 8'd0;
      threshold  = 8'd20;
      leak_shift = 3'd0;
      refrac_len = 3'd2;
      step_valid = 1'b0;
      x          = 64'd0;
      sel_idx    = 2'd0;

      repeat (2) @(negedge clk);
      check_out("reset", 1'b0, 4'h0);
      check_eq("reset_done0", 32'(cfg_done0), 32'd0);
      check_u("reset", 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Weights are still zero: a step produces a valid pulse but no change.
      do_step(ONES64);
      check_out("noweights", 1'b1, 4'h0);
      check_u("noweights", 0, 0);
      @(negedge clk);
      check_eq("ov_pulse", 32'(out_valid0), 32'd0);

      // 256 weight bits = 32 bytes of 0xFF.
      for (int i = 0; i < 31; i++) send_byte(8'hFF);
      check_eq("done_early0", 32'(cfg_done0), 32'd0);
      check_eq("done_early1", 32'(cfg_done1), 32'd0);
      send_byte(8'hFF);
      check_eq("done_last0", 32'(cfg_done0), 32'd1);
      check_eq("done_last1", 32'(cfg_done1), 32'd1);
      send_byte(8'h00);
      check_eq("done_extra", 32'(cfg_done0), 32'd1);

      // threshold 20, 8 inputs active: 8, 16, then 24 fires.
      do_step(64'hFF);
      check_out("int1", 1'b1, 4'h0);
      check_u("int1", 8, 8);
      do_step(64'hFF);
      check_u("int2", 16, 16);
      do_step(64'hFF);
      check_out("fire", 1'b1, 4'hF);
      check_u("fire", 0, 4);

      // Idle cycle: spikes held, no valid, membrane unchanged.
      @(negedge clk);
      check_out("idle", 1'b0, 4'hF);
      check_u("idle", 0, 4);

      // Refractory for two steps, then integration resumes.
      do_step(64'hFF);
      check_out("ref1", 1'b1, 4'h0);
      check_u("ref1", 0, 4);
      do_step(64'hFF);
      check_u("ref2", 0, 4);
      do_step(64'hFF);
      check_out("ref_end", 1'b1, 4'h0);
      check_u("ref_end", 8, 12);

      // Leak: reach 40/44 with 32 active inputs, then halve with x=0.
      threshold  = 8'd127;
      refrac_len = 3'd0;
      do_step(64'h0000_0000_FFFF_FFFF);
      check_u("to40", 40, 44);
      leak_shift = 3'd1;
      do_step(64'd0);
      check_u("leak1", 20, 22);
      do_step(64'd0);
      check_u("leak2", 10, 11);
      do_step(64'd0);
      check_u("leak3", 5, 6);
      do_step(64'd0);
      check_u("leak4", 3, 3);

      // Saturation: 3+64=67, then 131 clamps to 127 and fires at threshold 127.
      leak_shift = 3'd0;
      do_step(ONES64);
      check_out("sat_pre", 1'b1, 4'h0);
      check_u("sat_pre", 67, 67);
      do_step(ONES64);
      check_out("sat_fire", 1'b1, 4'hF);
      check_u("sat_fire", 0, 0);
      do_step(64'd0);
      check_out("norefrac", 1'b1, 4'h0);
      check_u("norefrac", 0, 0);
      do_step(ONES64);
      check_u("pre_rst", 64, 64);

      // Reset asserted while a step is being presented.
      @(negedge clk);
      step_valid = 1'b1;
      x          = ONES64;
      #2;
      rst_n = 1'b0;
      #1;
      check_out("midrst", 1'b0, 4'h0);
      check_u("midrst", 0, 0);
      check_eq("midrst_done", 32'(cfg_done0), 32'd0);
      @(negedge clk);
      step_valid = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);
      // Weights were cleared, so an all-ones input adds nothing.
      do_step(ONES64);
      check_out("post_rst", 1'b1, 4'h0);
      check_u("post_rst", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
